// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and types for the data-memory responder.
// Holds the MMIO address map, the STATUS bit positions, the address-decode
// enum and the decode helper used by dmem_responder.
package dmem_pkg;

    localparam int unsigned DATA_W = 32;

    // MMIO window at the very top of the 32-bit word-address space
    localparam logic [31:0] MMIO_CYCLE   = 32'hFFFF_FFF0;
    localparam logic [31:0] MMIO_TX      = 32'hFFFF_FFF1;
    localparam logic [31:0] MMIO_STATUS  = 32'hFFFF_FFF2;
    localparam logic [31:0] MMIO_SCRATCH = 32'hFFFF_FFF3;

    // STATUS register layout; bits [15:0] carry the FIFO count
    localparam int unsigned ST_COUNT_W = 16;
    localparam int unsigned ST_FULL    = 16;
    localparam int unsigned ST_EMPTY   = 17;
    localparam int unsigned ST_OVF     = 24;
    localparam int unsigned ST_BADADDR = 25;

    typedef enum logic [2:0] {
        DEC_RAM,
        DEC_CYCLE,
        DEC_TX,
        DEC_STATUS,
        DEC_SCRATCH,
        DEC_BAD
    } dec_e;

    // Full 32-bit compare; anything not RAM and not a known register is BAD
    function automatic dec_e decode_addr(input logic [31:0] addr, input logic [31:0] depth);
        if (addr < depth) begin
            return DEC_RAM;
        end
        case (addr)
            MMIO_CYCLE:   return DEC_CYCLE;
            MMIO_TX:      return DEC_TX;
            MMIO_STATUS:  return DEC_STATUS;
            MMIO_SCRATCH: return DEC_SCRATCH;
            default:      return DEC_BAD;
        endcase
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: transmit FIFO with a registered head word.
// Ports:
//   clock, reset     - rising-edge clock, synchronous active-high reset
//   push, push_data  - enqueue request and its word
//   pop              - dequeue request (ignored when empty)
//   head_valid       - registered: FIFO holds at least one entry
//   head_data        - registered head word, 0 when empty
//   count            - number of stored entries
//   full, empty      - occupancy flags
//   drop             - strobe: push rejected because full and no pop
module tx_fifo #(
    parameter int unsigned TX_DEPTH = 8,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              head_valid,
    output logic [DATA_W-1:0] head_data,
    output logic [15:0]       count,
    output logic              full,
    output logic              empty,
    output logic              drop
);

    localparam int unsigned PTR_W = $clog2(TX_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] slot_q [TX_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] head_d;
    logic              valid_q;
    logic              do_push;
    logic              do_pop;

    assign full  = (cnt_q == CNT_W'(TX_DEPTH));
    assign empty = (cnt_q == '0);
    assign count = 16'(cnt_q);

    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    assign cnt_d   = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);

    // Next head: the slot after the current head, or the incoming word when
    // the FIFO is (or becomes) a single-entry queue holding only that word.
    always_comb begin
        head_d = head_q;
        if (cnt_d == '0) begin
            head_d = '0;
        end else if (do_pop) begin
            if (cnt_q == CNT_W'(1)) begin
                head_d = push_data;
            end else begin
                head_d = slot_q[rd_ptr_q + PTR_W'(1)];
            end
        end else if (empty) begin
            head_d = push_data;
        end
    end

    // Pointers, count and registered head
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            valid_q <= (cnt_d != '0);
        end
    end

    // Storage is not reset; only slots behind the count are ever read
    always_ff @(posedge clock) begin
        if (!reset && do_push) begin
            slot_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_valid = valid_q;
    assign head_data  = head_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: serves the pipeline's dmem port with word RAM at low
// addresses and an MMIO window at the top of the address space
// (CYCLE counter, TX FIFO, sticky STATUS, SCRATCH).
// Build option: DMEM_CYCLE_COUNTER_EN builds the free-running CYCLE counter;
// without it CYCLE reads 0 and is still a legal (non-error) address.
// Ports:
//   clock, reset  - rising-edge clock, synchronous active-high reset
//   address_dmem  - word address, treated as a request every cycle
//   data, wren    - store data and store enable
//   q_dmem        - registered read data (1-cycle latency, read-before-write)
//   tx_valid      - TX FIFO head valid
//   tx_data       - TX FIFO head word
//   tx_ready      - consumer accepts the head
//   irq_err       - overflow | bad_addr
module dmem_responder #(
    parameter int unsigned DEPTH    = 4096,
    parameter int unsigned TX_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic        tx_valid,
    output logic [31:0] tx_data,
    input  logic        tx_ready,
    output logic        irq_err
);

    import dmem_pkg::*;

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    dec_e              dec;
    logic [ADDR_W-1:0] ram_idx;
    logic [31:0]       mem [DEPTH];
    logic [31:0]       rdata;
    logic [31:0]       status_word;
    logic [31:0]       cycle_val;
    logic [31:0]       scratch_q;
    logic              ovf_q;
    logic              bad_q;
    logic              wr_en;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_valid;
    logic [31:0]       fifo_head;
    logic [15:0]       fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_drop;
    logic              status_wr;

    assign dec     = decode_addr(address_dmem, 32'(DEPTH));
    assign ram_idx = address_dmem[ADDR_W-1:0];

    // Stores presented during reset are discarded
    assign wr_en     = wren && !reset;
    assign fifo_push = wr_en && (dec == DEC_TX);
    assign fifo_pop  = fifo_valid && tx_ready;
    assign status_wr = wr_en && (dec == DEC_STATUS);

    tx_fifo #(
        .TX_DEPTH (TX_DEPTH),
        .DATA_W   (DATA_W)
    ) u_tx_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (fifo_push),
        .push_data  (data),
        .pop        (fifo_pop),
        .head_valid (fifo_valid),
        .head_data  (fifo_head),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .drop       (fifo_drop)
    );

`ifdef DMEM_CYCLE_COUNTER_EN
    logic [31:0] cycle_q;

    // Free-running, wraps naturally at 2^32
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    assign cycle_val = cycle_q;
`else
    assign cycle_val = '0;
`endif

    // RAM contents survive reset
    always_ff @(posedge clock) begin
        if (wr_en && (dec == DEC_RAM)) begin
            mem[ram_idx] <= data;
        end
    end

    // STATUS view of pre-edge state
    always_comb begin
        status_word                   = '0;
        status_word[ST_COUNT_W-1:0]   = fifo_count;
        status_word[ST_FULL]          = fifo_full;
        status_word[ST_EMPTY]         = fifo_empty;
        status_word[ST_OVF]           = ovf_q;
        status_word[ST_BADADDR]       = bad_q;
    end

    // Read mux; every source is pre-edge so same-cycle writes return old data
    always_comb begin
        rdata = '0;
        case (dec)
            DEC_RAM:     rdata = mem[ram_idx];
            DEC_CYCLE:   rdata = cycle_val;
            DEC_TX:      rdata = fifo_valid ? fifo_head : 32'h0;
            DEC_STATUS:  rdata = status_word;
            DEC_SCRATCH: rdata = scratch_q;
            default:     rdata = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_dmem <= '0;
        end else begin
            q_dmem <= rdata;
        end
    end

    // Sticky error bits: W1C, with a same-cycle new event taking priority
    always_ff @(posedge clock) begin
        if (reset) begin
            ovf_q <= 1'b0;
            bad_q <= 1'b0;
        end else begin
            ovf_q <= (ovf_q && !(status_wr && data[ST_OVF])) || fifo_drop;
            bad_q <= (bad_q && !(status_wr && data[ST_BADADDR])) || (dec == DEC_BAD);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            scratch_q <= '0;
        end else if (wr_en && (dec == DEC_SCRATCH)) begin
            scratch_q <= data;
        end
    end

    assign tx_valid = fifo_valid;
    assign tx_data  = fifo_head;
    assign irq_err  = ovf_q | bad_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed vector table, hand-written FIFO,
// counter and reset sequences, then randomized traffic against a
// queue-based reference model.
module tb_dmem_responder;

    localparam int unsigned DEPTH    = 4096;
    localparam int unsigned TX_DEPTH = 8;

    localparam logic [31:0] A_CYC = 32'hFFFF_FFF0;
    localparam logic [31:0] A_TX  = 32'hFFFF_FFF1;
    localparam logic [31:0] A_ST  = 32'hFFFF_FFF2;
    localparam logic [31:0] A_SCR = 32'hFFFF_FFF3;

    logic        clock;
    logic        reset;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        tx_ready;
    logic        irq_err;

    int checks = 0;
    int errors = 0;

    dmem_responder #(
        .DEPTH    (DEPTH),
        .TX_DEPTH (TX_DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .irq_err      (irq_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        rdy;
        logic        chk_q;
        logic [31:0] exp_q;
        logic        exp_valid;
        logic [31:0] exp_txd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    logic [31:0] ram_m [logic [31:0]];
    logic [31:0] fifo_m [$];
    logic [31:0] cyc_m;
    logic [31:0] scr_m;
    logic        ovf_m;
    logic        bad_m;
    logic [31:0] mexp_q;
    logic        mq_known;

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] d, input logic we,
                                input logic rdy, input logic cq, input logic [31:0] eq,
                                input logic ev, input logic [31:0] et, input logic ei);
        vec_t v;
        v.addr = a; v.wdata = d; v.we = we; v.rdy = rdy; v.chk_q = cq;
        v.exp_q = eq; v.exp_valid = ev; v.exp_txd = et; v.exp_irq = ei;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we, input logic rdy);
        address_dmem = a;
        data         = d;
        wren         = we;
        tx_ready     = rdy;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One request cycle of the reference model, applied to pre-edge state
    task automatic model_step(input logic rst, input logic [31:0] a, input logic [31:0] d,
                              input logic we, input logic rdy);
        logic ovf_evt;
        logic bad_evt;
        logic pop;
        int   sz;
        if (rst) begin
            mexp_q   = '0;
            mq_known = 1'b1;
            fifo_m.delete();
            cyc_m = '0;
            scr_m = '0;
            ovf_m = 1'b0;
            bad_m = 1'b0;
        end else begin
            sz       = fifo_m.size();
            mq_known = 1'b1;
            ovf_evt  = 1'b0;
            bad_evt  = 1'b0;
            if (a < DEPTH) begin
                if (ram_m.exists(a)) mexp_q = ram_m[a];
                else begin mexp_q = '0; mq_known = 1'b0; end
            end else if (a == A_CYC) mexp_q = cyc_m;
            else if (a == A_TX) mexp_q = (sz > 0) ? fifo_m[0] : 32'h0;
            else if (a == A_ST) begin
                mexp_q = 32'(sz);
                if (sz == TX_DEPTH) mexp_q = mexp_q + 32'h0001_0000;
                if (sz == 0) mexp_q = mexp_q + 32'h0002_0000;
                if (ovf_m) mexp_q = mexp_q + 32'h0100_0000;
                if (bad_m) mexp_q = mexp_q + 32'h0200_0000;
            end else if (a == A_SCR) mexp_q = scr_m;
            else begin
                mexp_q  = '0;
                bad_evt = 1'b1;
            end
            pop = (sz > 0) && rdy;
            if (pop) void'(fifo_m.pop_front());
            if (we && a == A_TX) begin
                if (sz < TX_DEPTH || pop) fifo_m.push_back(d);
                else ovf_evt = 1'b1;
            end
            if (we && a == A_ST) begin
                if (d[24]) ovf_m = 1'b0;
                if (d[25]) bad_m = 1'b0;
            end
            if (ovf_evt) ovf_m = 1'b1;
            if (bad_evt) bad_m = 1'b1;
            if (we && a == A_SCR) scr_m = d;
            if (we && a < DEPTH) ram_m[a] = d;
`ifdef DMEM_CYCLE_COUNTER_EN
            cyc_m = cyc_m + 32'd1;
`endif
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] a;
        logic [31:0] d;
        logic        we;
        logic        rdy;
        logic        rst;
        int          sel;

        reset = 1'b1;
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        check("reset_q", q_dmem, 32'h0);
        check("reset_valid", tx_valid, 1'b0);
        check("reset_txd", tx_data, 32'h0);
        check("reset_irq", irq_err, 1'b0);
        reset = 1'b0;

        // addr, data, we, rdy, chk_q, exp_q, exp_valid, exp_txd, exp_irq
        vecs.push_back(mk(32'd5,      32'hDEAD_BEEF, 1, 0, 0, 32'h0,         0, 32'h0,  0));
        vecs.push_back(mk(32'd5,      32'h0,         0, 0, 1, 32'hDEAD_BEEF, 0, 32'h0,  0));
        vecs.push_back(mk(32'd5,      32'h1,         1, 0, 1, 32'hDEAD_BEEF, 0, 32'h0,  0));
        vecs.push_back(mk(32'd5,      32'h0,         0, 0, 1, 32'h1,         0, 32'h0,  0));
        vecs.push_back(mk(A_SCR,      32'h0,         0, 0, 1, 32'h0,         0, 32'h0,  0));
        vecs.push_back(mk(A_SCR,      32'h1234_5678, 1, 0, 1, 32'h0,         0, 32'h0,  0));
        vecs.push_back(mk(A_SCR,      32'h0,         0, 0, 1, 32'h1234_5678, 0, 32'h0,  0));
        vecs.push_back(mk(A_ST,       32'h0,         0, 0, 1, 32'h0002_0000, 0, 32'h0,  0));
        vecs.push_back(mk(A_TX,       32'hA5,        1, 0, 1, 32'h0,         1, 32'hA5, 0));
        vecs.push_back(mk(A_TX,       32'h0,         0, 0, 1, 32'hA5,        1, 32'hA5, 0));
        vecs.push_back(mk(A_ST,       32'h0,         0, 0, 1, 32'h0000_0001, 1, 32'hA5, 0));
        vecs.push_back(mk(32'h0001_0000, 32'h0,      0, 0, 1, 32'h0,         1, 32'hA5, 1));
        vecs.push_back(mk(A_ST,       32'h0,         0, 0, 1, 32'h0200_0001, 1, 32'hA5, 1));
        vecs.push_back(mk(A_ST,       32'h0200_0000, 1, 0, 1, 32'h0200_0001, 1, 32'hA5, 0));
        vecs.push_back(mk(A_ST,       32'h0,         0, 0, 1, 32'h0000_0001, 1, 32'hA5, 0));
        vecs.push_back(mk(32'd4096,   32'h0,         0, 0, 1, 32'h0,         1, 32'hA5, 1));
        vecs.push_back(mk(A_ST,       32'h0200_0000, 1, 0, 1, 32'h0200_0001, 1, 32'hA5, 0));
        vecs.push_back(mk(32'd4095,   32'h55,        1, 0, 0, 32'h0,         1, 32'hA5, 0));
        vecs.push_back(mk(32'd4095,   32'h0,         0, 0, 1, 32'h55,        1, 32'hA5, 0));
        vecs.push_back(mk(A_SCR,      32'h0,         0, 1, 1, 32'h1234_5678, 0, 32'h0,  0));
        vecs.push_back(mk(32'hFFFF_FFF4, 32'h0,      0, 1, 1, 32'h0,         0, 32'h0,  1));
        vecs.push_back(mk(A_ST,       32'h0300_0000, 1, 1, 1, 32'h0202_0000, 0, 32'h0,  0));
        vecs.push_back(mk(32'hFFFF_FFEF, 32'h77,     1, 0, 1, 32'h0,         0, 32'h0,  1));
        vecs.push_back(mk(A_ST,       32'h0200_0000, 1, 0, 1, 32'h0202_0000, 0, 32'h0,  0));
        vecs.push_back(mk(A_TX,       32'h11,        1, 1, 1, 32'h0,         1, 32'h11, 0));
        vecs.push_back(mk(A_ST,       32'h0,         0, 1, 1, 32'h0000_0001, 0, 32'h0,  0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].rdy);
            tick();
            if (vecs[i].chk_q) check($sformatf("vec%0d_q", i), q_dmem, vecs[i].exp_q);
            check($sformatf("vec%0d_valid", i), tx_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_txd", i), tx_data, vecs[i].exp_txd);
            check($sformatf("vec%0d_irq", i), irq_err, vecs[i].exp_irq);
        end

        // Overflow: 9 pushes into 8 entries with the consumer stalled
        for (int k = 1; k <= 9; k++) begin
            drive(A_TX, 32'(k), 1'b1, 1'b0);
            tick();
        end
        check("ovf_irq", irq_err, 1'b1);
        check("ovf_head", tx_data, 32'd1);
        drive(A_ST, 32'h0, 1'b0, 1'b0);
        tick();
        check("ovf_status", q_dmem, 32'h0101_0008);
        drive(A_SCR, 32'h0, 1'b0, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("drain_valid%0d", k), tx_valid, 1'b1);
            check($sformatf("drain_data%0d", k), tx_data, 32'(k));
            tick();
        end
        check("drain_done_valid", tx_valid, 1'b0);
        drive(A_ST, 32'h0, 1'b0, 1'b1);
        tick();
        check("drain_status", q_dmem, 32'h0102_0000);
        drive(A_ST, 32'h0100_0000, 1'b1, 1'b0);
        tick();
        check("ovf_clear_irq", irq_err, 1'b0);

        // Full FIFO: push coinciding with a pop is accepted
        for (int k = 0; k < 8; k++) begin
            drive(A_TX, 32'(100 + k), 1'b1, 1'b0);
            tick();
        end
        drive(A_TX, 32'd42, 1'b1, 1'b1);
        tick();
        drive(A_ST, 32'h0, 1'b0, 1'b0);
        tick();
        check("fullpp_status", q_dmem, 32'h0001_0008);
        check("fullpp_irq", irq_err, 1'b0);
        drive(A_SCR, 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("fullpp_data%0d", k), tx_data, (k < 7) ? 32'(101 + k) : 32'd42);
            tick();
        end
        check("fullpp_empty", tx_valid, 1'b0);

        // Cycle counter: two reads 10 edges apart, with a write ignored between
        drive(A_CYC, 32'h0, 1'b0, 1'b0);
        tick();
        v1 = q_dmem;
        drive(A_CYC, 32'h0, 1'b1, 1'b0);
        tick();
        drive(A_CYC, 32'h0, 1'b0, 1'b0);
        repeat (9) tick();
        v2 = q_dmem;
`ifdef DMEM_CYCLE_COUNTER_EN
        check("cycle_delta", v2 - v1, 32'd10);
`else
        check("cycle_v1_zero", v1, 32'h0);
        check("cycle_v2_zero", v2, 32'h0);
`endif

        // Reset in the middle of traffic
        drive(A_TX, 32'h111, 1'b1, 1'b0); tick();
        drive(A_TX, 32'h222, 1'b1, 1'b0); tick();
        drive(32'hFFFF_FFF8, 32'h0, 1'b0, 1'b0); tick();
        drive(A_SCR, 32'd99, 1'b1, 1'b0); tick();
        drive(A_SCR, 32'h0, 1'b0, 1'b0); tick();
        check("pre_rst_q", q_dmem, 32'd99);
        check("pre_rst_valid", tx_valid, 1'b1);
        check("pre_rst_txd", tx_data, 32'h111);
        check("pre_rst_irq", irq_err, 1'b1);
        reset = 1'b1;
        drive(A_SCR, 32'hFFFF, 1'b1, 1'b1);
        tick();
        check("rst_q", q_dmem, 32'h0);
        check("rst_valid", tx_valid, 1'b0);
        check("rst_txd", tx_data, 32'h0);
        check("rst_irq", irq_err, 1'b0);
        reset = 1'b0;
        drive(A_CYC, 32'h0, 1'b0, 1'b0);
        tick();
        check("post_rst_cycle", q_dmem, 32'h0);
        drive(A_SCR, 32'h0, 1'b0, 1'b0);
        tick();
        check("post_rst_scratch", q_dmem, 32'h0);

        // Randomized traffic against the reference model
        reset = 1'b1;
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        model_step(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1, 2: a = 32'($urandom_range(0, 7));
                3:       a = 32'(DEPTH - 1);
                4:       a = A_CYC;
                5, 6:    a = A_TX;
                7:       a = A_ST;
                8:       a = A_SCR;
                default: begin
                    case ($urandom_range(0, 3))
                        0:       a = 32'(DEPTH);
                        1:       a = 32'h8000_0000;
                        2:       a = 32'hFFFF_FFEF;
                        default: a = 32'hFFFF_FFF4 + 32'($urandom_range(0, 11));
                    endcase
                end
            endcase
            d   = $urandom;
            we  = 1'($urandom_range(0, 1));
            rdy = (n < 300) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 6);
            reset = rst;
            drive(a, d, we, rdy);
            model_step(rst, a, d, we, rdy);
            tick();
            if (mq_known) check("rnd_q", q_dmem, mexp_q);
            check("rnd_valid", tx_valid, (fifo_m.size() != 0));
            check("rnd_txd", tx_data, (fifo_m.size() != 0) ? fifo_m[0] : 32'h0);
            check("rnd_irq", irq_err, ovf_m | bad_m);
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
